// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for the instruction prefetch buffer: the fetched-entry payload
// and its default widths.
package Pipe_Buf_Reg_PKG;

    localparam int unsigned PC_W_DEF  = 9;
    localparam int unsigned INS_W_DEF = 32;

    typedef struct packed {
        logic [PC_W_DEF-1:0]  pc;
        logic [INS_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched entries with flush; head is read combinationally
// and reads as all-zero when empty.
module fetch_fifo
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    output entry_t           o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit,
// captures 1-cycle-latency responses into a FIFO, and flushes on redirect.
module instr_prefetch_buffer
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned INS_W = INS_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             id_ready,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_pending;
    logic [PC_W-1:0]  r_pend_pc;

    logic [CNT_W-1:0] w_count;
    logic             w_credit_ok;
    logic             w_push;
    logic             w_pop;
    entry_t           w_push_data;
    entry_t           w_head;

    // Outstanding response reserves a slot so the FIFO can never overflow.
    assign w_credit_ok = (w_count + CNT_W'(r_pending)) < CNT_W'(DEPTH);
    assign imem_req    = reset && !redirect && w_credit_ok;
    assign imem_addr   = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_pending  <= 1'b0;
            r_pend_pc  <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_pending  <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            r_pending <= imem_req;
            if (imem_req) begin
                r_pend_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + PC_W'(4);
            end
        end
    end

    assign w_push            = r_pending && !redirect;
    assign w_pop             = if_valid && id_ready;
    assign w_push_data.pc    = r_pend_pc;
    assign w_push_data.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign if_valid = (w_count != '0);
    assign if_pc    = w_head.pc;
    assign if_instr = w_head.instr;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.PC_W(9), .INS_W(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [8:0]  m_fetch;
    logic [8:0]  m_pend_pc;
    bit          m_pend;
    logic [31:0] nxt_rdata;
    int          errors = 0;
    int          checks = 0;
    int          req_cnt;

    logic        c_req;
    logic [8:0]  c_addr;
    logic        c_valid;
    logic [8:0]  c_pc;
    logic [31:0] c_instr;

    function automatic logic [31:0] instr_of(input logic [8:0] pc);
        return 32'hA500_0003 | (32'(pc) << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit rst, input bit rd, input logic [8:0] rpc, input bit idr);
        bit         e_req;
        logic [8:0] e_pc;
        logic [31:0] e_instr;
        @(negedge clk);
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = idr;
        imem_rdata  = nxt_rdata;
        #1;
        c_req   = imem_req;
        c_addr  = imem_addr;
        c_valid = if_valid;
        c_pc    = if_pc;
        c_instr = if_instr;

        e_req   = rst && !rd && ((mq.size() + int'(m_pend)) < DEPTH);
        e_pc    = (mq.size() > 0) ? mq[0].pc : 9'h000;
        e_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
        chk("model imem_req", 32'(c_req), 32'(e_req));
        if (e_req) chk("model imem_addr", 32'(c_addr), 32'(m_fetch));
        chk("model if_valid", 32'(c_valid), 32'(mq.size() > 0));
        chk("model if_pc", 32'(c_pc), 32'(e_pc));
        chk("model if_instr", c_instr, e_instr);

        if (c_req) req_cnt++;
        nxt_rdata = c_req ? instr_of(c_addr) : $urandom;

        if (!rst) begin
            mq.delete();
            m_fetch = 9'h000;
            m_pend  = 1'b0;
        end else if (rd) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = rpc;
        end else begin
            if (mq.size() > 0 && idr) void'(mq.pop_front());
            if (m_pend) mq.push_back('{m_pend_pc, instr_of(m_pend_pc)});
            m_pend = e_req;
            if (e_req) begin
                m_pend_pc = m_fetch;
                m_fetch   = m_fetch + 9'd4;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        imem_rdata  = '0;
        nxt_rdata   = '0;
        m_fetch     = '0;
        m_pend_pc   = '0;
        m_pend      = 1'b0;
        req_cnt     = 0;
        repeat (2) @(posedge clk);

        // Reset cycle: nothing requested, nothing valid
        step(0, 0, 9'h0, 1);
        chk("rst imem_req", 32'(c_req), 32'h0);
        chk("rst if_valid", 32'(c_valid), 32'h0);

        // Streaming from reset
        step(1, 0, 9'h0, 1);
        chk("s0 imem_req", 32'(c_req), 32'h1);
        chk("s0 imem_addr", 32'(c_addr), 32'h000);
        chk("s0 if_valid", 32'(c_valid), 32'h0);
        step(1, 0, 9'h0, 1);
        chk("s1 imem_addr", 32'(c_addr), 32'h004);
        chk("s1 if_valid", 32'(c_valid), 32'h0);
        step(1, 0, 9'h0, 1);
        chk("s2 imem_addr", 32'(c_addr), 32'h008);
        chk("s2 if_valid", 32'(c_valid), 32'h1);
        chk("s2 if_pc", 32'(c_pc), 32'h000);
        step(1, 0, 9'h0, 1);
        chk("s3 if_pc", 32'(c_pc), 32'h004);
        chk("s3 if_instr", c_instr, 32'hA500_0403);
        repeat (6) step(1, 0, 9'h0, 1);

        // Stalled from reset: fills exactly DEPTH entries
        step(0, 0, 9'h0, 0);
        req_cnt = 0;
        repeat (8) step(1, 0, 9'h0, 0);
        chk("stall req count", 32'(req_cnt), 32'd4);
        chk("stall imem_req", 32'(c_req), 32'h0);
        chk("stall if_pc", 32'(c_pc), 32'h000);

        // Single pop at full
        step(1, 0, 9'h0, 1);
        chk("pop1 imem_req", 32'(c_req), 32'h0);
        step(1, 0, 9'h0, 0);
        chk("pop1 refill req", 32'(c_req), 32'h1);
        chk("pop1 refill addr", 32'(c_addr), 32'h010);
        chk("pop1 if_pc", 32'(c_pc), 32'h004);
        step(1, 0, 9'h0, 0);
        chk("pop1 credit hold", 32'(c_req), 32'h0);
        step(1, 0, 9'h0, 0);

        // Redirect with a response in flight and three entries held
        step(1, 0, 9'h0, 1);
        step(1, 0, 9'h0, 0);
        chk("rd pre req", 32'(c_req), 32'h1);
        chk("rd pre addr", 32'(c_addr), 32'h014);
        step(1, 1, 9'h040, 1);
        chk("rd imem_req", 32'(c_req), 32'h0);
        step(1, 0, 9'h0, 1);
        chk("rd+1 if_valid", 32'(c_valid), 32'h0);
        chk("rd+1 imem_addr", 32'(c_addr), 32'h040);
        step(1, 0, 9'h0, 1);
        chk("rd+2 if_valid", 32'(c_valid), 32'h0);
        step(1, 0, 9'h0, 1);
        chk("rd+3 if_pc", 32'(c_pc), 32'h040);
        repeat (4) step(1, 0, 9'h0, 1);

        // Address wrap at the top of the PC space
        step(1, 1, 9'h1FC, 1);
        step(1, 0, 9'h0, 1);
        chk("wrap addr0", 32'(c_addr), 32'h1FC);
        step(1, 0, 9'h0, 1);
        chk("wrap addr1", 32'(c_addr), 32'h000);
        step(1, 0, 9'h0, 1);
        chk("wrap pc0", 32'(c_pc), 32'h1FC);
        step(1, 0, 9'h0, 1);
        chk("wrap pc1", 32'(c_pc), 32'h000);
        repeat (3) step(1, 0, 9'h0, 1);

        // Reset mid-operation with two entries and a pending response
        step(1, 1, 9'h080, 0);
        repeat (3) step(1, 0, 9'h0, 0);
        step(0, 0, 9'h0, 0);
        chk("mrst imem_req", 32'(c_req), 32'h0);
        chk("mrst if_valid", 32'(c_valid), 32'h1);
        step(1, 0, 9'h0, 1);
        chk("mrst+1 if_valid", 32'(c_valid), 32'h0);
        chk("mrst+1 imem_addr", 32'(c_addr), 32'h000);
        step(1, 0, 9'h0, 1);
        step(1, 0, 9'h0, 1);
        chk("mrst+3 if_pc", 32'(c_pc), 32'h000);

        // Mixed stalls with a redirect in the middle
        for (int i = 0; i < 40; i++) begin
            if (i == 20) step(1, 1, 9'h100, 1'($urandom));
            else         step(1, 0, 9'h0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
